// File: rtl/cla_pipe_adder_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_if
// Handshake and data bundle for the pipelined carry-lookahead adder.
//   Upstream side  : in_valid, in_ready, a, b, cin, sub
//   Downstream side: out_valid, out_ready, sum, cout, overflow, grp_p, grp_g
// Modports:
//   master - the environment (operand source and result consumer)
//   slave  - the adder itself
// -----------------------------------------------------------------------------
interface cla_pipe_adder_if #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
);
   localparam int NG = WIDTH / GROUP;

   // Operand side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;

   // Result side
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic [NG-1:0]    grp_p;
   logic [NG-1:0]    grp_g;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow, grp_p, grp_g
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow, grp_p, grp_g
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Three-stage pipelined carry-lookahead adder/subtractor.
//   Stage 1: operand conditioning (invert b for subtract), bit propagate and
//            generate, carry-in selection.
//   Stage 2: first-level group P/G over GROUP-bit groups, second-level
//            lookahead for the group carry-ins, bit carries inside each group.
//   Stage 3: sum, carry out, signed overflow and group P/G outputs.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - cla_pipe_adder_if.slave: valid/ready operand input, valid/ready
//            result output, sum/cout/overflow/grp_p/grp_g
// Parameters:
//   WIDTH  - operand width; a multiple of GROUP and at least GROUP
//   GROUP  - bits per first-level lookahead group (NG = WIDTH/GROUP groups)
// The whole pipeline shares one advance enable (adv); when the result is
// stalled every stage holds, so no skid storage is needed.
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input logic             clk,
   input logic             rst_n,
   cla_pipe_adder_if.slave bus
);
   localparam int NG = WIDTH / GROUP;

   // ---------------------------------------------------------------------------
   // Lookahead carry into position n of a block, as a flat sum of products:
   //   c[n] = g[n-1] | p[n-1]g[n-2] | ... | p[n-1]...p[0]ci
   // Each term is independent, so no ripple chain forms inside a block.
   // ---------------------------------------------------------------------------
   function automatic logic la_carry_bit(input logic [GROUP-1:0] p,
                                         input logic [GROUP-1:0] g,
                                         input logic             ci,
                                         input int               n);
      logic c;
      logic t;
      c = 1'b0;
      for (int j = 0; j < n; j++) begin
         t = g[j];
         for (int m = j + 1; m < n; m++) t = t & p[m];
         c = c | t;
      end
      t = ci;
      for (int m = 0; m < n; m++) t = t & p[m];
      return c | t;
   endfunction

   // Same structure across the NG groups (second lookahead level).
   function automatic logic la_carry_grp(input logic [NG-1:0] p,
                                         input logic [NG-1:0] g,
                                         input logic          ci,
                                         input int            n);
      logic c;
      logic t;
      c = 1'b0;
      for (int j = 0; j < n; j++) begin
         t = g[j];
         for (int m = j + 1; m < n; m++) t = t & p[m];
         c = c | t;
      end
      t = ci;
      for (int m = 0; m < n; m++) t = t & p[m];
      return c | t;
   endfunction

   // ---------------------------------------------------------------------------
   // Handshake: a single advance enable for all stages.
   // ---------------------------------------------------------------------------
   logic adv;
   logic s3_valid;

   assign adv          = bus.out_ready | ~s3_valid;
   assign bus.in_ready = adv;

   // ---------------------------------------------------------------------------
   // Stage 1: conditioned operands -> bit P/G and carry-in
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] bb;
   logic [WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s1_g;
   logic             s1_c0;
   logic             s1_valid;

   // Subtract is a + ~b + 1, so the inverted b and forced carry-in do it all.
   assign bb = bus.b ^ {WIDTH{bus.sub}};

   // NOTE: every clocked process uses non-blocking assignments so all stages
   // sample the previous cycle's values together; blocking here would let a
   // stage see its predecessor's new value in the same edge.
   // NOTE: datapath registers are reset along with the valid bits so the
   // outputs read as zero after reset; nothing else depends on that.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_p     <= '0;
         s1_g     <= '0;
         s1_c0    <= 1'b0;
         s1_valid <= 1'b0;
      end else if (adv) begin
         s1_p     <= bus.a ^ bb;
         s1_g     <= bus.a & bb;
         s1_c0    <= bus.sub | bus.cin;
         s1_valid <= bus.in_valid;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: two-level lookahead
   // ---------------------------------------------------------------------------
   logic [NG-1:0]    grp_pc;   // first-level group propagate
   logic [NG-1:0]    grp_gc;   // first-level group generate
   logic [NG:0]      grp_cin;  // carry into each group; [NG] is the final carry
   logic [WIDTH:0]   carry_c;  // carry into every bit plus carry out

   // NOTE: each combinational process assigns a default before the loops so
   // every bit is written on every path and no latch is inferred.
   always_comb begin
      grp_pc = '0;
      grp_gc = '0;
      for (int k = 0; k < NG; k++) begin
         grp_pc[k] = &s1_p[k*GROUP +: GROUP];
         grp_gc[k] = la_carry_bit(s1_p[k*GROUP +: GROUP],
                                  s1_g[k*GROUP +: GROUP], 1'b0, GROUP);
      end
   end

   // Group carry-ins straight from group P/G and c0; with NG=1 this reduces
   // to grp_cin[0]=c0 and grp_cin[1]=G0|P0&c0.
   always_comb begin
      grp_cin = '0;
      for (int k = 0; k <= NG; k++) begin
         grp_cin[k] = la_carry_grp(grp_pc, grp_gc, s1_c0, k);
      end
   end

   // Bit carries inside a group only look back to that group's carry-in.
   always_comb begin
      carry_c = '0;
      for (int k = 0; k < NG; k++) begin
         for (int i = 0; i < GROUP; i++) begin
            carry_c[k*GROUP + i] = la_carry_bit(s1_p[k*GROUP +: GROUP],
                                                s1_g[k*GROUP +: GROUP],
                                                grp_cin[k], i);
         end
      end
      carry_c[WIDTH] = grp_cin[NG];
   end

   logic [WIDTH:0]   s2_c;
   logic [WIDTH-1:0] s2_p;
   logic [NG-1:0]    s2_gp;
   logic [NG-1:0]    s2_gg;
   logic             s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_c     <= '0;
         s2_p     <= '0;
         s2_gp    <= '0;
         s2_gg    <= '0;
         s2_valid <= 1'b0;
      end else if (adv) begin
         s2_c     <= carry_c;
         s2_p     <= s1_p;
         s2_gp    <= grp_pc;
         s2_gg    <= grp_gc;
         s2_valid <= s1_valid;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 3: result registers (held while the consumer stalls)
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] s3_sum;
   logic             s3_cout;
   logic             s3_ovf;
   logic [NG-1:0]    s3_gp;
   logic [NG-1:0]    s3_gg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_sum   <= '0;
         s3_cout  <= 1'b0;
         s3_ovf   <= 1'b0;
         s3_gp    <= '0;
         s3_gg    <= '0;
         s3_valid <= 1'b0;
      end else if (adv) begin
         s3_sum   <= s2_p ^ s2_c[WIDTH-1:0];
         s3_cout  <= s2_c[WIDTH];
         // Signed overflow: carry into the sign bit differs from carry out.
         s3_ovf   <= s2_c[WIDTH-1] ^ s2_c[WIDTH];
         s3_gp    <= s2_gp;
         s3_gg    <= s2_gg;
         s3_valid <= s2_valid;
      end
   end

   assign bus.out_valid = s3_valid;
   assign bus.sum       = s3_sum;
   assign bus.cout      = s3_cout;
   assign bus.overflow  = s3_ovf;
   assign bus.grp_p     = s3_gp;
   assign bus.grp_g     = s3_gg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Scoreboarded bench for cla_pipe_adder (WIDTH=16, GROUP=4). The stimulus
// pushes an expected result when an operand pair is accepted; a monitor pops
// and compares whenever a result is transferred out.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;
   localparam int W  = 16;
   localparam int G  = 4;
   localparam int NG = W / G;

   typedef struct packed {
      logic [W-1:0]  sum;
      logic          cout;
      logic          ovf;
      logic [NG-1:0] gp;
      logic [NG-1:0] gg;
   } exp_t;

   logic clk;
   logic rst_n;

   cla_pipe_adder_if #(.WIDTH(W), .GROUP(G)) bus ();

   cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_out    = 0;
   exp_t sb_q[$];
   bit   rand_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: plain integer arithmetic, group P/G from per-group sums.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         e;
      logic [W-1:0] bv;
      logic         c0;
      logic [W:0]   full;
      logic [W-1:0] low;
      logic [G:0]   gs;
      logic [G-1:0] pa;
      logic [G-1:0] pb;
      bv    = sub ? ~b : b;
      c0    = sub ? 1'b1 : cin;
      full  = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, c0};
      low   = {1'b0, a[W-2:0]} + {1'b0, bv[W-2:0]} + {{(W-1){1'b0}}, c0};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = low[W-1] ^ full[W];
      for (int k = 0; k < NG; k++) begin
         pa = a[k*G +: G];
         pb = bv[k*G +: G];
         gs = {1'b0, pa} + {1'b0, pb};
         e.gp[k] = &(pa ^ pb);
         e.gg[k] = gs[G];
      end
      return e;
   endfunction

   // Drive one operand pair at posedge+#1 and hold it until accepted.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input exp_t e);
      bit ok = 1'b0;
      int t  = 0;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      while (!ok && t < 200) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      bus.in_valid = 1'b0;
      if (ok) sb_q.push_back(e);
      else check("accept_timeout", 32'd0, 32'd1);
   endtask

   // Hand-computed sum/cout/overflow; group fields from the reference.
   task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub,
                           input logic [W-1:0] hs, input logic hc, input logic ho);
      exp_t e;
      e      = model(a, b, cin, sub);
      e.sum  = hs;
      e.cout = hc;
      e.ovf  = ho;
      send(a, b, cin, sub, e);
   endtask

   function automatic logic [31:0] act_word();
      exp_t x;
      x.sum  = bus.sum;
      x.cout = bus.cout;
      x.ovf  = bus.overflow;
      x.gp   = bus.grp_p;
      x.gg   = bus.grp_g;
      return {6'd0, x};
   endfunction

   // Monitor: compare every transferred result against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_out++;
         if (sb_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
         else check("result", act_word(), {6'd0, sb_q.pop_front()});
      end
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b1;
      #2 rst_n = 1'b0;

      // Reset with in_valid asserted: nothing may enter.
      bus.in_valid = 1'b1;
      bus.a        = 16'h1234;
      bus.b        = 16'h4321;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_outputs", act_word(), 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;

      // Directed vectors.
      send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send_dir(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      send_dir(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send_dir(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      send_dir(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
      send_dir(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      // Group fields for the full-carry vector, by hand: p=FFFE, g=0001.
      begin
         exp_t e;
         e = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, gp: 4'b1110, gg: 4'b0001};
         send(16'hFFFF, 16'h0001, 1'b0, 1'b0, e);
      end
      repeat (6) @(posedge clk);
      #1;

      // Backpressure: k+k for k=1..5, stall two cycles at the first result.
      fork
         begin
            for (int k = 1; k <= 5; k++)
               send_dir(W'(k), W'(k), 1'b0, 1'b0, W'(2 * k), 1'b0, 1'b0);
         end
         begin
            bit seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(posedge clk);
               #1;
               seen = bus.out_valid;
            end
            check("bp_first_valid", {31'd0, seen}, 32'd1);
            bus.out_ready = 1'b0;
            for (int i = 0; i < 2; i++) begin
               @(negedge clk);
               check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
               check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
               check("bp_hold_sum", {16'd0, bus.sum}, 32'd2);
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      check("bp_drained", sb_q.size(), 32'd0);

      // Reset mid-flight: two accepted items must never appear.
      send_dir(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
      send_dir(16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      begin
         int seen_before;
         seen_before = n_out;
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         repeat (6) @(posedge clk);
         @(negedge clk);
         check("midrst_no_output", n_out - seen_before, 32'd0);
         check("midrst_idle", {31'd0, bus.out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Reference-model phase with random backpressure.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [W-1:0] ra;
               logic [W-1:0] rb;
               logic         rc;
               logic         rs;
               ra = W'($urandom);
               rb = W'($urandom);
               rc = 1'($urandom);
               rs = 1'($urandom);
               send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join

      for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
      check("final_drain", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
